huffman_decoder: RTL and testbench

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

---
 rtl/huffman_decoder_if.sv | 27 ++
 rtl/huffman_decoder.sv | 139 +++++++++++++
 tb/tb_huffman_decoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/huffman_decoder_if.sv
// Bit-serial Huffman decoder bus: code table load, serial bit input, symbol/error output.
interface huffman_decoder_if #(parameter int CNT_W = 8);
  logic             tbl_load;
  logic [7:0]       HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0]       M1, M2, M3, M4, M5, M6;
  logic             bit_valid;
  logic             bit_in;
  logic             flush;
  logic             bit_ready;
  logic             sym_valid;
  logic [2:0]       sym_out;
  logic             err;
  logic             tbl_err;
  logic [CNT_W-1:0] sym_count;

  modport master (
    output tbl_load, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
           bit_valid, bit_in, flush,
    input  bit_ready, sym_valid, sym_out, err, tbl_err, sym_count
  );

  modport slave (
    input  tbl_load, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
           bit_valid, bit_in, flush,
    output bit_ready, sym_valid, sym_out, err, tbl_err, sym_count
  );
endinterface

// File: rtl/huffman_decoder.sv
// Bit-serial decoder for a 6-symbol Huffman table of codes up to 8 bits, MSB first.
//   state  | meaning
//   EMPTY  | no valid code table; incoming bits are ignored
//   DECODE | table valid; one code bit accepted per clock
module huffman_decoder #(
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              reset,
  huffman_decoder_if.slave bus
);

  typedef enum logic {EMPTY, DECODE} state_t;

  state_t           state;
  logic [7:0]       hc_q [1:6];
  logic [7:0]       m_q  [1:6];
  logic [7:0]       acc;
  logic [3:0]       len;
  logic [CNT_W-1:0] cnt;
  logic             sym_valid_q;
  logic [2:0]       sym_out_q;
  logic             err_q;
  logic             tbl_err_q;

  logic [7:0] hc_in [1:6];
  logic [7:0] m_in  [1:6];
  logic       tbl_ok;
  logic [7:0] acc_next;
  logic [3:0] len_next;
  logic [8:0] len_mask;
  logic       hit;
  logic [2:0] hit_sym;

  assign hc_in[1] = bus.HC1;
  assign hc_in[2] = bus.HC2;
  assign hc_in[3] = bus.HC3;
  assign hc_in[4] = bus.HC4;
  assign hc_in[5] = bus.HC5;
  assign hc_in[6] = bus.HC6;
  assign m_in[1]  = bus.M1;
  assign m_in[2]  = bus.M2;
  assign m_in[3]  = bus.M3;
  assign m_in[4]  = bus.M4;
  assign m_in[5]  = bus.M5;
  assign m_in[6]  = bus.M6;

  // An absent symbol (mask 0) may carry any code value; only present ones are checked.
  always_comb begin
    logic any_present;
    logic all_ok;
    any_present = 1'b0;
    all_ok      = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (m_in[i] != 8'd0) begin
        any_present = 1'b1;
        if ((m_in[i] & (m_in[i] + 8'd1)) != 8'd0) all_ok = 1'b0;
        if ((hc_in[i] & ~m_in[i]) != 8'd0)        all_ok = 1'b0;
      end
    end
    tbl_ok = any_present & all_ok;
  end

  // Descending scan so the lowest-numbered matching symbol is the one kept.
  always_comb begin
    acc_next = {acc[6:0], bus.bit_in};
    len_next = len + 4'd1;
    len_mask = (9'd1 << len_next) - 9'd1;
    hit      = 1'b0;
    hit_sym  = 3'd0;
    for (int i = 6; i >= 1; i--) begin
      if (m_q[i] != 8'd0 && {1'b0, m_q[i]} == len_mask &&
          (acc_next & m_q[i]) == hc_q[i]) begin
        hit     = 1'b1;
        hit_sym = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      for (int i = 1; i <= 6; i++) begin
        hc_q[i] <= 8'd0;
        m_q[i]  <= 8'd0;
      end
      acc         <= 8'd0;
      len         <= 4'd0;
      cnt         <= '0;
      sym_valid_q <= 1'b0;
      sym_out_q   <= 3'd0;
      err_q       <= 1'b0;
      tbl_err_q   <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (bus.tbl_load) begin
        for (int i = 1; i <= 6; i++) begin
          hc_q[i] <= hc_in[i];
          m_q[i]  <= m_in[i];
        end
        acc       <= 8'd0;
        len       <= 4'd0;
        cnt       <= '0;
        tbl_err_q <= ~tbl_ok;
        state     <= tbl_ok ? DECODE : EMPTY;
      end else if (state == DECODE) begin
        if (bus.flush) begin
          acc   <= 8'd0;
          len   <= 4'd0;
          err_q <= (len != 4'd0);
        end else if (bus.bit_valid) begin
          if (hit) begin
            sym_valid_q <= 1'b1;
            sym_out_q   <= hit_sym;
            acc         <= 8'd0;
            len         <= 4'd0;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end else if (len_next == 4'd8) begin
            err_q <= 1'b1;
            acc   <= 8'd0;
            len   <= 4'd0;
          end else begin
            acc <= acc_next;
            len <= len_next;
          end
        end
      end
    end
  end

  assign bus.bit_ready = (state == DECODE);
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_out   = sym_out_q;
  assign bus.err       = err_q;
  assign bus.tbl_err   = tbl_err_q;
  assign bus.sym_count = cnt;

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: expected symbols/errors queued with their due cycle.
module tb_huffman_decoder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  huffman_decoder_if #(.CNT_W(8)) bus();
  huffman_decoder #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int         due;
    logic [3:0] code;   // {err, sym}
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [7:0] t_hc [1:6];
  logic [7:0] t_m  [1:6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [3:0] code;
    exp_t       e;
    if (!reset && (bus.sym_valid || bus.err)) begin
      code = {bus.err, bus.sym_valid ? bus.sym_out : 3'd0};
      chk("excl", {31'd0, bus.sym_valid & bus.err}, 32'd0);
      if (sb.size() == 0) chk("unexpected", {30'd0, bus.sym_valid, bus.err}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sym", {28'd0, code}, {28'd0, e.code});
        chk("lat", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic send(input logic b, input logic [3:0] e);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    if (e != 4'd0) sb.push_back(exp_t'{due: cyc + 1, code: e});
    tick();
    bus.bit_valid = 1'b0;
  endtask

  task automatic load(input logic with_bit);
    bus.HC1 = t_hc[1]; bus.HC2 = t_hc[2]; bus.HC3 = t_hc[3];
    bus.HC4 = t_hc[4]; bus.HC5 = t_hc[5]; bus.HC6 = t_hc[6];
    bus.M1  = t_m[1];  bus.M2  = t_m[2];  bus.M3  = t_m[3];
    bus.M4  = t_m[4];  bus.M5  = t_m[5];  bus.M6  = t_m[6];
    bus.tbl_load = 1'b1;
    if (with_bit) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b0;
    end
    tick();
    bus.tbl_load  = 1'b0;
    bus.bit_valid = 1'b0;
  endtask

  task automatic do_flush(input logic expect_err);
    bus.flush = 1'b1;
    if (expect_err) sb.push_back(exp_t'{due: cyc + 1, code: 4'b1000});
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic table_a();
    t_hc = '{8'd0, 8'd2, 8'd6, 8'd14, 8'd30, 8'd31};
    t_m  = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd31};
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"},   {31'd0, bus.bit_ready}, 32'd0);
    chk({tag, "_tblerr"},  {31'd0, bus.tbl_err},   32'd0);
    chk({tag, "_symv"},    {31'd0, bus.sym_valid}, 32'd0);
    chk({tag, "_err"},     {31'd0, bus.err},       32'd0);
    chk({tag, "_symout"},  {29'd0, bus.sym_out},   32'd0);
    chk({tag, "_count"},   {24'd0, bus.sym_count}, 32'd0);
  endtask

  initial begin
    bus.tbl_load = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.flush = 1'b0;
    bus.HC1 = 8'd0; bus.HC2 = 8'd0; bus.HC3 = 8'd0; bus.HC4 = 8'd0; bus.HC5 = 8'd0; bus.HC6 = 8'd0;
    bus.M1  = 8'd0; bus.M2  = 8'd0; bus.M3  = 8'd0; bus.M4  = 8'd0; bus.M5  = 8'd0; bus.M6  = 8'd0;
    repeat (2) tick();
    samp();
    check_idle_outputs("rst");
    reset = 1'b0;
    tick();

    // no table yet: bits must be ignored
    send(1'b0, 4'd0); send(1'b1, 4'd0); send(1'b0, 4'd0);
    samp();
    chk("empty_ready", {31'd0, bus.bit_ready}, 32'd0);

    // basic decode, back-to-back codewords 0 | 10 | 11111
    table_a();
    load(1'b0);
    samp();
    chk("a_tblerr", {31'd0, bus.tbl_err},   32'd0);
    chk("a_ready",  {31'd0, bus.bit_ready}, 32'd1);
    send(1'b0, 4'd1);
    send(1'b1, 4'd0); send(1'b0, 4'd2);
    send(1'b1, 4'd0); send(1'b1, 4'd0); send(1'b1, 4'd0); send(1'b1, 4'd0); send(1'b1, 4'd6);
    repeat (2) tick();
    samp();
    chk("a_count",  {24'd0, bus.sym_count}, 32'd3);
    chk("a_hold",   {29'd0, bus.sym_out},   32'd6);

    // symbol 6 absent: eight ones overrun the longest code
    t_m[6] = 8'd0;
    load(1'b0);
    for (int i = 0; i < 7; i++) send(1'b1, 4'd0);
    send(1'b1, 4'b1000);
    repeat (2) tick();
    samp();
    chk("ovr_count", {24'd0, bus.sym_count}, 32'd0);

    // malformed mask rejects the table
    table_a();
    t_m[3] = 8'd5;
    load(1'b0);
    samp();
    chk("bad_tblerr", {31'd0, bus.tbl_err},   32'd1);
    chk("bad_ready",  {31'd0, bus.bit_ready}, 32'd0);
    send(1'b0, 4'd0); send(1'b0, 4'd0);
    table_a();
    load(1'b0);
    samp();
    chk("good_tblerr", {31'd0, bus.tbl_err},   32'd0);
    chk("good_ready",  {31'd0, bus.bit_ready}, 32'd1);

    // flush of a partial codeword, then flush with nothing pending
    send(1'b1, 4'd0); send(1'b1, 4'd0);
    do_flush(1'b1);
    send(1'b1, 4'd0); send(1'b0, 4'd2);
    do_flush(1'b0);
    tick();

    // reload with a coincident bit mid-codeword
    send(1'b1, 4'd0); send(1'b1, 4'd0); send(1'b1, 4'd0);
    load(1'b1);
    samp();
    chk("ld_count", {24'd0, bus.sym_count}, 32'd0);
    send(1'b1, 4'd0); send(1'b0, 4'd2);
    repeat (2) tick();
    samp();
    chk("ld_count2", {24'd0, bus.sym_count}, 32'd1);

    // duplicated codes: lowest symbol number wins
    t_hc = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    t_m  = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    load(1'b0);
    send(1'b1, 4'd1);

    // full 8-bit codeword matches on the last bit; a near miss errors
    t_hc = '{8'd0, 8'd0, 8'hA5, 8'd0, 8'd0, 8'd0};
    t_m  = '{8'd0, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd0};
    load(1'b0);
    send(1'b1, 4'd0); send(1'b0, 4'd0); send(1'b1, 4'd0); send(1'b0, 4'd0);
    send(1'b0, 4'd0); send(1'b1, 4'd0); send(1'b0, 4'd0); send(1'b1, 4'd3);
    send(1'b1, 4'd0); send(1'b0, 4'd0); send(1'b1, 4'd0); send(1'b0, 4'd0);
    send(1'b0, 4'd0); send(1'b1, 4'd0); send(1'b0, 4'd0); send(1'b0, 4'b1000);

    // symbol counter saturates
    t_hc = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    t_m  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    load(1'b0);
    for (int i = 0; i < 260; i++) send(1'b0, 4'd1);
    repeat (2) tick();
    samp();
    chk("sat_count", {24'd0, bus.sym_count}, 32'd255);

    // reset in the middle of a 5-bit codeword
    table_a();
    load(1'b0);
    send(1'b0, 4'd1);
    send(1'b1, 4'd0); send(1'b1, 4'd0); send(1'b1, 4'd0);
    reset = 1'b1;
    samp();
    check_idle_outputs("mid_rst");
    reset = 1'b0;
    tick();
    send(1'b1, 4'd0); send(1'b0, 4'd0);
    samp();
    chk("post_rst_ready", {31'd0, bus.bit_ready}, 32'd0);

    repeat (3) tick();
    chk("drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
